// File: rtl/muldiv_if.sv
// Execute-stage handshake between the pipeline and the iterative multiply/divide unit.
interface muldiv_if #(parameter int XLEN = 32);
  logic            StartE;
  logic            FlushE;
  logic [2:0]      FunctE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic [XLEN-1:0] MulDivResultE;
  logic            DoneE;
  logic            BusyE;

  modport master (output StartE, FlushE, FunctE, SrcAE, SrcBE,
                  input  MulDivResultE, DoneE, BusyE);
  modport slave  (input  StartE, FlushE, FunctE, SrcAE, SrcBE,
                  output MulDivResultE, DoneE, BusyE);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply and restoring divide on magnitudes.
// Optional MULDIV_FAST_MUL_EN: multiplies use a single-cycle combinational multiplier.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic    clk,
  input  logic    reset,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic [2:0]        funct;
  logic              neg;
  logic [XLEN-1:0]   opa;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   result;
  logic              done;

  logic              is_mul, a_sg, b_sg, a_neg, b_neg, neg_in, div0, ovf, fast;
  logic [XLEN-1:0]   a_mag, b_mag, spec_res, fres;

  // Decode of the operation presented in EX
  always_comb begin
    is_mul   = !bus.FunctE[2];
    a_sg     = is_mul ? (bus.FunctE[1] ^ bus.FunctE[0]) : !bus.FunctE[0];
    b_sg     = is_mul ? (bus.FunctE[1:0] == 2'b01) : !bus.FunctE[0];
    a_neg    = a_sg & bus.SrcAE[XLEN-1];
    b_neg    = b_sg & bus.SrcBE[XLEN-1];
    a_mag    = a_neg ? -bus.SrcAE : bus.SrcAE;
    b_mag    = b_neg ? -bus.SrcBE : bus.SrcBE;
    // Remainder follows the dividend sign; everything else is sign xor
    neg_in   = (!is_mul && bus.FunctE[1]) ? a_neg : (a_neg ^ b_neg);
    div0     = !is_mul && (bus.SrcBE == '0);
    ovf      = !is_mul && !bus.FunctE[0] && (bus.SrcAE == {1'b1, {(XLEN-1){1'b0}}})
               && (bus.SrcBE == '1);
    spec_res = '0;
    if (div0)     spec_res = bus.FunctE[1] ? bus.SrcAE : '1;
    else if (ovf) spec_res = bus.FunctE[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fa, fb, fprod;
  always_comb begin
    fa    = {{XLEN{a_neg}}, bus.SrcAE};
    fb    = {{XLEN{b_neg}}, bus.SrcBE};
    fprod = fa * fb;
    fast  = is_mul;
    fres  = (bus.FunctE[1:0] == 2'b00) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
  end
`else
  always_comb begin
    fast = 1'b0;
    fres = '0;
  end
`endif

  logic [XLEN:0]     madd, dsub;
  logic [2*XLEN-1:0] acc_nxt, pm;
  logic [XLEN-1:0]   q, r, res_fin;

  // One iteration step; acc holds {hi,multiplier} or {remainder,quotient}
  always_comb begin
    madd = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opa : {XLEN{1'b0}})};
    dsub = acc[2*XLEN-1:XLEN-1] - {1'b0, opa};
    if (!funct[2])    acc_nxt = {madd, acc[XLEN-1:1]};
    else if (dsub[XLEN]) acc_nxt = {acc[2*XLEN-2:0], 1'b0};
    else              acc_nxt = {dsub[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    pm = neg ? -acc_nxt : acc_nxt;
    q  = neg ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    r  = neg ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    if (!funct[2]) res_fin = (funct[1:0] == 2'b00) ? pm[XLEN-1:0] : pm[2*XLEN-1:XLEN];
    else           res_fin = funct[1] ? r : q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      funct  <= '0;
      neg    <= 1'b0;
      opa    <= '0;
      acc    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else if (bus.FlushE) begin
      state <= IDLE;
      count <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.StartE) begin
          funct <= bus.FunctE;
          neg   <= neg_in;
          count <= '0;
          if (div0 || ovf) begin
            result <= spec_res;
            done   <= 1'b1;
            state  <= DONE;
          end else if (fast) begin
            result <= fres;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            opa   <= is_mul ? a_mag : b_mag;
            acc   <= {{XLEN{1'b0}}, (is_mul ? b_mag : a_mag)};
            state <= CALC;
          end
        end
        CALC: begin
          acc   <= acc_nxt;
          count <= count + 1'b1;
          if (count == CW'(XLEN-1)) begin
            result <= res_fin;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.MulDivResultE = result;
  assign bus.DoneE         = done;
  assign bus.BusyE         = (state == CALC) || (state == IDLE && bus.StartE && !bus.FlushE);
endmodule
